// File: rtl/display_scan_scheduler_pkg.sv
// Shared types and constants for the 7-segment scan scheduler: FSM states,
// active-low segment encodings and the per-digit anode select table.
package display_scan_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ON    = 2'd1,
    BLANK = 2'd2
  } scan_state_e;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low segment patterns, bit7 = dp (kept off)
  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;

  localparam logic [3:0] AN_OFF = 4'hF;

  // Entry i has only bit i low
  localparam logic [3:0][3:0] AN_TABLE = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  localparam logic [1:0] FIRST_DIGIT = 2'd3;

endpackage

// File: rtl/display_scan_scheduler_if.sv
// Panel-side bundle: BCD digits, enable and blink mask in; seg/an pins,
// current digit index and frame tick out.
interface display_scan_scheduler_if;

  logic       in_enable;
  logic [3:0] in_digit3;
  logic [3:0] in_digit2;
  logic [3:0] in_digit1;
  logic [3:0] in_digit0;
  logic [3:0] in_blink_mask;
  logic [7:0] out_seg;
  logic [3:0] out_an;
  logic [1:0] out_digit_index;
  logic       out_frame_tick;

  // Counter side driving the digits and consuming the display status
  modport master (
    output in_enable, in_digit3, in_digit2, in_digit1, in_digit0, in_blink_mask,
    input  out_seg, out_an, out_digit_index, out_frame_tick
  );

  // Scheduler side
  modport slave (
    input  in_enable, in_digit3, in_digit2, in_digit1, in_digit0, in_blink_mask,
    output out_seg, out_an, out_digit_index, out_frame_tick
  );

endinterface

// File: rtl/display_scan_scheduler_bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder; codes A-F show blank.
module bcd_to_seg
  import display_scan_scheduler_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_scan_scheduler.sv
// Four-digit multiplexed 7-segment scan with dead-time blanking between digits.
// Optional adjust-mode blinking is built when DISPLAY_BLINK_EN is defined.
module display_scan_scheduler
  import display_scan_scheduler_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int BLINK_CYCLES = 25000000
) (
  input  logic                     in_clock,
  input  logic                     in_reset,
  display_scan_scheduler_if.slave  bus
);

  localparam int CNT_W = $clog2(DIGIT_CYCLES);
  localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(DIGIT_CYCLES - BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(DIGIT_CYCLES - 1);

  scan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       digit_q, digit_d;
  logic [3:0]       an_q, an_d;
  logic [7:0]       seg_q, seg_d;
  logic             tick_q, tick_d;
  logic             enter_on;
  logic [3:0]       digit_in;
  logic [7:0]       seg_dec;
  logic             blink_hide;

  // Next state: slot counter runs 0..DIGIT_CYCLES-1 across ON then BLANK
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    enter_on = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = FIRST_DIGIT;
        if (bus.in_enable) begin
          state_d  = ON;
          enter_on = 1'b1;
        end
      end
      ON: begin
        if (!bus.in_enable) begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = FIRST_DIGIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == ON_LAST) state_d = BLANK;
        end
      end
      BLANK: begin
        if (!bus.in_enable) begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = FIRST_DIGIT;
        end else if (cnt_q == SLOT_LAST) begin
          state_d  = ON;
          cnt_d    = '0;
          idx_d    = idx_q - 2'd1;
          enter_on = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = FIRST_DIGIT;
      end
    endcase
  end

  always_comb begin
    digit_in = bus.in_digit3;
    case (idx_d)
      2'd0:    digit_in = bus.in_digit0;
      2'd1:    digit_in = bus.in_digit1;
      2'd2:    digit_in = bus.in_digit2;
      default: digit_in = bus.in_digit3;
    endcase
  end

  // Digit is captured only on the ON-entry edge and held for the whole slot
  assign digit_d = enter_on ? digit_in : digit_q;

  bcd_to_seg u_dec (
    .bcd_i (digit_d),
    .seg_o (seg_dec)
  );

`ifdef DISPLAY_BLINK_EN
  localparam int BLK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_CYCLES - 1);

  logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             phase_q, phase_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q + 1'b1;
    phase_d     = phase_q;
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
  end

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign blink_hide = ~phase_d & bus.in_blink_mask[idx_d];
`else
  localparam int blink_cycles_unused = BLINK_CYCLES;
  logic blink_mask_unused;
  assign blink_mask_unused = ^bus.in_blink_mask;
  assign blink_hide        = 1'b0;
`endif

  // Outputs are computed from next state so they move on the transition edge
  always_comb begin
    an_d   = AN_OFF;
    seg_d  = SEG_BLANK;
    tick_d = enter_on && (idx_d == FIRST_DIGIT);
    if (state_d == ON) begin
      an_d  = AN_TABLE[idx_d];
      seg_d = blink_hide ? SEG_BLANK : seg_dec;
    end
  end

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= FIRST_DIGIT;
      an_q    <= AN_OFF;
      seg_q   <= SEG_BLANK;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      tick_q  <= tick_d;
    end
  end

  always_ff @(posedge in_clock) begin
    digit_q <= digit_d;
  end

  assign bus.out_an          = an_q;
  assign bus.out_seg         = seg_q;
  assign bus.out_digit_index = idx_q;
  assign bus.out_frame_tick  = tick_q;

endmodule

// File: doc/display_scan_scheduler.md
# display_scan_scheduler

Time-multiplexes a shared active-low 8-bit segment bus across four 7-segment digits for the stopwatch front panel. It latches one BCD digit per scan slot, decodes it, and inserts a dead-time blanking gap between digits to suppress ghosting. It also applies a per-digit blink mask for adjust mode. It sits between the minute/second counters and the board `seg`/`an` pins, replacing ad-hoc scan logic in the top level.

## Interface
- `DIGIT_CYCLES`, 100000: total clock cycles per digit slot (ON + BLANK).
- `BLANK_CYCLES`, 1000: cycles per slot with all anodes off. Legal range is 1 ≤ BLANK_CYCLES < DIGIT_CYCLES.
- `BLINK_CYCLES`, 25000000: half-period of the blink phase in cycles.
- `in_clock` in 1: system clock.
- `in_reset` in 1: reset, asynchronous, active-high.
- `in_enable` in 1: scanning enabled; when low the display is dark.
- `in_digit3` in 4: BCD value for the leftmost digit (minutes tens).
- `in_digit2` in 4: BCD value for minutes units.
- `in_digit1` in 4: BCD value for seconds tens.
- `in_digit0` in 4: BCD value for the rightmost digit (seconds units).
- `in_blink_mask` in 4: bit i = 1 makes digit i blink.
- `out_seg` out 8: segments, active-low; bit7 is dp and is always 1.
- `out_an` out 4: anodes, active-low; bit i drives digit i.
- `out_digit_index` out 2: index of the digit currently owning the bus.
- `out_frame_tick` out 1: one-cycle pulse at the start of each frame.

## Operation
- The FSM has three states: IDLE, ON and BLANK.
  - IDLE: out_an = 4'hF, out_seg = 8'hFF, index = 3. Moves to ON when in_enable = 1.
  - ON: out_an has only bit[index] low. out_seg = decode(digit latched at ON entry). Lasts DIGIT_CYCLES − BLANK_CYCLES cycles, then moves to BLANK.
  - BLANK: out_an = 4'hF, out_seg = 8'hFF. Lasts BLANK_CYCLES cycles. Then index decrements (0 wraps to 3) and the FSM returns to ON.
- Scan order is 3, 2, 1, 0, 3, …
- The digit value is sampled once, on the ON-entry edge. Input changes during a slot do not affect out_seg until the next slot.
- Decoding:
  - BCD 0–9 use the shared encoding table (0 = 8'hC0, 1 = 8'hF9, 2 = 8'hA4, 3 = 8'hB0, 4 = 8'h99, 5 = 8'h92, 6 = 8'h82, 7 = 8'hF8, 8 = 8'h80, 9 = 8'h90).
  - 4'hA–4'hF decode to 8'hFF (blank), while the anode is still driven.
- out_frame_tick is 1 for exactly the single cycle in which ON is entered with index 3, including the first ON after leaving IDLE.
- in_enable low in ON or BLANK: at the next edge the FSM goes to IDLE, outputs go dark, index returns to 3 and the slot counter clears.
- The slot counter width is $clog2(DIGIT_CYCLES). It counts 0..DIGIT_CYCLES−1 within a slot and never saturates.
- Blink is available only with DISPLAY_BLINK_EN (see Configuration).

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Output values change on the same edge as the state transition.
- in_enable sampled high in IDLE at edge k gives, at edge k: out_an = 4'b0111 and out_seg = decode(in_digit3 as sampled at k).
- Every slot is exactly DIGIT_CYCLES cycles. A frame is 4·DIGIT_CYCLES cycles; out_frame_tick pulses every frame.
- Reset values:
  - out_an = 4'hF, out_seg = 8'hFF
  - out_digit_index = 3, out_frame_tick = 0
  - state = IDLE, blink phase = 1, all counters = 0
- Reset asserted mid-slot clears the outputs immediately, without waiting for a clock edge.

## Configuration
- With `DISPLAY_BLINK_EN` defined:
  - A free-running blink counter toggles the blink phase every BLINK_CYCLES cycles. It runs independently of scan state and of in_enable, and is cleared only by reset.
  - When phase = 0 and in_blink_mask[index] = 1, out_seg = 8'hFF during ON; out_an is still driven.
  - The mask is evaluated every cycle, so a mask change takes effect on the next edge.
- Without it: the blink counter is not built, in_blink_mask is ignored (port retained), and digits are always shown.

## Structure
- A shared package holds:
  - the FSM state typedef (IDLE, ON, BLANK)
  - the SEG_BLANK = 8'hFF constant
  - the ten BCD segment-encoding constants
  - the anode one-hot-low table indexed by digit
- One sub-module, `bcd_to_seg`: a combinational decoder that uses the package constants and maps invalid codes to SEG_BLANK.

## Test plan
Bench parameters: DIGIT=8, BLANK=2, BLINK=16.
- Reset -> out_an = F, out_seg = FF, out_digit_index = 3, out_frame_tick = 0, with in_enable = 1 held during reset.
- Enable with digits 3..0 = 1, 2, 3, 4 -> out_an 0111 / out_seg F9 for 6 cycles, then 1111 for 2 cycles, then 1011/A4, 1101/B0, 1110/99; out_frame_tick pulses each 32 cycles.
- in_digit2 = 4'hA -> out_an 1011 with out_seg FF. Changing in_digit1 mid-slot 1 -> out_seg holds its old value until the next slot-1 entry.
- Blink (macro defined), mask = 4'b1100 -> during phase 0 digits 3 and 2 show FF and digits 1 and 0 show their values; during phase 1 all digits show. Macro undefined -> all digits always shown.
- Drop in_enable mid-ON of digit 1 -> next edge out_an = F. Re-enable -> restarts at digit 3 with an out_frame_tick pulse.
- Assert in_reset mid-ON -> out_an = F and out_seg = FF before the next clock edge. Release -> stays in IDLE until in_enable is sampled high.
